// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: opcodes, FSM states and control word shared by the accumulator sequencer
package acc_seq_pkg;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;
  typedef enum logic [1:0] {IDLE, EX1, EX2} state_t;
  typedef struct packed {
    logic in_oe;
    logic acc_oe;
    logic alu_oe;
    logic alu_sub;
    logic load_a;
    logic load_b;
    logic out_load;
    logic done;
  } ctrl_t;
  function automatic logic is_arith(logic [2:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/acc_seq_decode.sv
// acc_seq_decode: (state, latched op) -> bus strobes; the one place bus exclusivity is guarded
module acc_seq_decode
  import acc_seq_pkg::*;
(
  input  state_t     state_i,
  input  logic [2:0] op_i,
  output ctrl_t      ctrl_o
);
  // EX1 moves the operand onto the bus, EX2 writes the ALU result back
  always_comb begin
    ctrl_o = '0;
    if (state_i == EX1) begin
      ctrl_o.in_oe    = op_i inside {OP_LDA, OP_ADD, OP_SUB, OP_CLR};
      ctrl_o.load_a   = op_i inside {OP_LDA, OP_CLR};
      ctrl_o.load_b   = is_arith(op_i);
      ctrl_o.acc_oe   = op_i == OP_OUT;
      ctrl_o.out_load = op_i == OP_OUT;
      ctrl_o.done     = !is_arith(op_i);
    end else if (state_i == EX2) begin
      ctrl_o.alu_oe  = 1'b1;
      ctrl_o.alu_sub = op_i == OP_SUB;
      ctrl_o.load_a  = 1'b1;
      ctrl_o.done    = 1'b1;
    end
  end
  // at most one bus driver, and subtract only qualifies an active ALU drive
  always_comb assert ($onehot0({ctrl_o.in_oe, ctrl_o.acc_oe, ctrl_o.alu_oe}) && (ctrl_o.alu_oe || !ctrl_o.alu_sub));
endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: command-driven bus sequencer for the accumulator datapath; OPCOUNT_EN adds a done counter
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] imm_out,
  output logic              in_oe,
  output logic              acc_oe,
  output logic              alu_oe,
  output logic              alu_sub,
  output logic              load_a,
  output logic              load_b,
  output logic              out_load,
  input  logic              alu_cf,
  input  logic              alu_zf,
  output logic              cf,
  output logic              zf,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  op_count
);
  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic              cf_q, cf_d, zf_q, zf_d, err_q;
  ctrl_t             ctrl;
  logic              accept;

  assign accept  = cmd_valid && ready_q;
  assign ready_d = state_d == IDLE;

  // state register; ready is registered so it stays low through reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end

  // next state: only arithmetic ops need the second execute cycle
  always_comb
    state_d = (state_q == IDLE && accept) ? EX1 :
              (state_q == EX1 && is_arith(op_q)) ? EX2 : IDLE;

  acc_seq_decode u_dec (
    .state_i (state_q),
    .op_i    (op_q),
    .ctrl_o  (ctrl)
  );

  // flags move only on the ALU write-back or on CLR
  always_comb begin
    cf_d = (state_q == EX2) ? alu_cf : (state_q == EX1 && op_q == OP_CLR) ? 1'b0 : cf_q;
    zf_d = (state_q == EX2) ? alu_zf : (state_q == EX1 && op_q == OP_CLR) ? 1'b1 : zf_q;
  end

  // command latch and flags; CLR latches a zero immediate so the bus carries 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q  <= OP_NOP;
      imm_q <= '0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      op_q  <= accept ? cmd_op : op_q;
      imm_q <= accept ? ((cmd_op == OP_CLR) ? '0 : cmd_data) : imm_q;
      cf_q  <= cf_d;
      zf_q  <= zf_d;
      err_q <= err_q || (state_q == EX1 && op_q > OP_CLR);
    end

`ifdef OPCOUNT_EN
  logic [CNT_W-1:0] cnt_q;
  // completed-command counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, ctrl.done};
  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif

  assign cmd_ready = ready_q;
  assign imm_out   = imm_q;
  assign in_oe     = ctrl.in_oe;
  assign acc_oe    = ctrl.acc_oe;
  assign alu_oe    = ctrl.alu_oe;
  assign alu_sub   = ctrl.alu_sub;
  assign load_a    = ctrl.load_a;
  assign load_b    = ctrl.load_b;
  assign out_load  = ctrl.out_load;
  assign done      = ctrl.done;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign err       = err_q;
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: scoreboard bench with a behavioural accumulator/ALU datapath model
module tb_acc_sequencer;
  import acc_seq_pkg::*;
  logic        clk = 0, rst_n = 0, cmd_valid = 0;
  logic [2:0]  cmd_op = 0;
  logic [7:0]  cmd_data = 0;
  logic        cmd_ready, in_oe, acc_oe, alu_oe, alu_sub, load_a, load_b, out_load;
  logic        alu_cf, alu_zf, cf, zf, done, err;
  logic [7:0]  imm_out;
  logic [15:0] op_count;
  logic [7:0]  acc_m = 8'h00, b_m = 8'h00, out_m = 8'hAA, bus_m, res_m;
  int          tests = 0, fails = 0, cyc = 0, done_cyc = -1;

  typedef struct {logic [7:0] ctl; logic [7:0] bus; logic cf, zf, err;} rec_t;
  rec_t q[$];

  localparam logic [7:0] C_LDA = 8'h89, C_AE1 = 8'h84, C_AE2 = 8'h29, C_SE2 = 8'h39, C_OUT = 8'h43, C_DONE = 8'h01;

  always #5 clk = ~clk;

  acc_sequencer #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .imm_out(imm_out),
    .in_oe(in_oe), .acc_oe(acc_oe), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .load_a(load_a), .load_b(load_b), .out_load(out_load),
    .alu_cf(alu_cf), .alu_zf(alu_zf), .cf(cf), .zf(zf),
    .done(done), .err(err), .op_count(op_count)
  );

  wire [7:0] ctl = {in_oe, acc_oe, alu_oe, alu_sub, load_a, load_b, out_load, done};

  assign bus_m = in_oe ? imm_out : acc_oe ? acc_m : alu_oe ? res_m : 8'h00;
  assign {alu_cf, res_m} = {1'b0, acc_m} + {1'b0, (alu_sub ? ~b_m : b_m)} + {8'h00, alu_sub};
  assign alu_zf = res_m == 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_a) acc_m <= bus_m;
    if (load_b) b_m <= bus_m;
    if (out_load) out_m <= bus_m;
  end

  always @(negedge clk) begin : monitor
    rec_t r;
    if (rst_n) begin
      tests++;
      if (!$onehot0({in_oe, acc_oe, alu_oe}) || (alu_sub && !alu_oe)) begin
        fails++;
        $display("FAIL bus_excl cyc=%0d got in/acc/alu/sub=%b%b%b%b want onehot0, sub only with alu", cyc, in_oe, acc_oe, alu_oe, alu_sub);
      end
      if (done && alu_oe) done_cyc = cyc;
      if (ctl != 8'h00) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output cyc=%0d got ctl=%h bus=%h want no strobes", cyc, ctl, bus_m);
        end else begin
          r = q.pop_front();
          if ({ctl, bus_m, cf, zf, err} !== {r.ctl, r.bus, r.cf, r.zf, r.err}) begin
            fails++;
            $display("FAIL scoreboard cyc=%0d got ctl=%h bus=%h cf=%b zf=%b err=%b want ctl=%h bus=%h cf=%b zf=%b err=%b",
                     cyc, ctl, bus_m, cf, zf, err, r.ctl, r.bus, r.cf, r.zf, r.err);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] b, input logic f_c, input logic f_z, input logic e);
    rec_t r;
    r.ctl = c; r.bus = b; r.cf = f_c; r.zf = f_z; r.err = e;
    q.push_back(r);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic flush();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_out();
    return {28'd0, cmd_ready, ctl, cf, zf, err, imm_out, op_count};
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int i, n;
    int a[3];
    logic [2:0] ops[3];
    ops = '{OP_OUT, OP_OUT, OP_ADD};
    #12 check("reset_outputs", all_out(), 64'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1 check("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    push(C_LDA, 8'h05, 0, 0, 0);
    send(OP_LDA, 8'h05);
    push(C_AE1, 8'h03, 0, 0, 0);
    push(C_AE2, 8'h08, 0, 0, 0);
    send(OP_ADD, 8'h03);
    flush();
    check("add_acc", 64'(acc_m), 64'h08);
    check("add_flags", {62'd0, cf, zf}, 64'd0);

    push(C_LDA, 8'h08, 0, 0, 0);
    send(OP_LDA, 8'h08);
    push(C_AE1, 8'h08, 0, 0, 0);
    push(C_SE2, 8'h00, 0, 0, 0);
    send(OP_SUB, 8'h08);
    flush();
    check("sub_acc", 64'(acc_m), 64'h00);
    check("sub_flags", {62'd0, cf, zf}, 64'd3);
    push(C_OUT, 8'h00, 1, 1, 0);
    send(OP_OUT, 8'h5A);
    flush();
    check("out_reg", 64'(out_m), 64'h00);
    check("out_flags_hold", {62'd0, cf, zf}, 64'd3);

    push(C_OUT, 8'h00, 1, 1, 0);
    push(C_OUT, 8'h00, 1, 1, 0);
    push(C_AE1, 8'h07, 1, 1, 0);
    push(C_AE2, 8'h07, 1, 1, 0);
    cmd_data = 8'h07;
    i = 0; n = 0;
    while (i < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (cmd_ready) begin
        cmd_valid = 1;
        cmd_op = ops[i];
        a[i] = cyc;
        i++;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 0;
    check("held_accepts", 64'(i), 64'd3);
    flush();
    check("held_accept1", 64'(a[1] - a[0]), 64'd2);
    check("held_accept2", 64'(a[2] - a[0]), 64'd4);
    check("held_add_done", 64'(done_cyc - a[0]), 64'd6);
    check("held_acc", 64'(acc_m), 64'h07);
    check("held_flags", {62'd0, cf, zf}, 64'd0);

    push(C_AE1, 8'h02, 0, 0, 0);
    send(OP_ADD, 8'h02);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check("async_reset_outputs", all_out(), 64'd0);
    repeat (2) @(negedge clk);
    check("reset_no_ex2", 64'(q.size()), 64'd0);
    check("reset_acc_kept", 64'(acc_m), 64'h07);
    rst_n = 1;
    @(posedge clk) #1 check("ready_after_abort", {63'd0, cmd_ready}, 64'd1);

    push(C_LDA, 8'hFF, 0, 0, 0);
    send(OP_LDA, 8'hFF);
    push(C_AE1, 8'h02, 0, 0, 0);
    push(C_AE2, 8'h01, 0, 0, 0);
    send(OP_ADD, 8'h02);
    flush();
    check("carry_acc", 64'(acc_m), 64'h01);
    check("carry_flags", {62'd0, cf, zf}, 64'd2);
    push(C_LDA, 8'h00, 1, 0, 0);
    send(OP_CLR, 8'h55);
    flush();
    check("clr_acc", 64'(acc_m), 64'h00);
    check("clr_flags", {62'd0, cf, zf}, 64'd1);

    push(C_DONE, 8'h00, 0, 1, 0);
    send(3'b111, 8'h33);
    flush();
    check("illegal_err", {63'd0, err}, 64'd1);
    push(C_DONE, 8'h00, 0, 1, 1);
    send(OP_NOP, 8'h00);
    flush();
`ifdef OPCOUNT_EN
    check("op_count", 64'(op_count), 64'd5);
`else
    check("op_count_tied", 64'(op_count), 64'd0);
`endif
    push(C_OUT, 8'h00, 0, 1, 1);
    send(OP_OUT, 8'h00);
    flush();
    check("err_sticky", {63'd0, err}, 64'd1);
    check("final_flags", {62'd0, cf, zf}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Command-driven control sequencer for the 8-bit bus-based accumulator datapath, i.e. the accumulator register plus the add/sub ALU.
- Accepts one command at a time over a valid/ready handshake.
- Drives the single shared bus, one driver per cycle, and generates load, output-enable and sub strobes.
- Latches the ALU carry and zero flags; sits between the tt_um top-level pin decode and the datapath.

Parameters:
DATA_W, 8, width of bus, immediate operand and accumulator
CNT_W, 16, width of completed-command counter (optional feature)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_op  input  3  opcode: 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 OUT, 101 CLR, 110/111 illegal
cmd_data  input  DATA_W  immediate operand
imm_out  output  DATA_W  latched immediate, valid on bus when in_oe=1
in_oe  output  1  immediate drives bus
acc_oe  output  1  accumulator drives bus
alu_oe  output  1  ALU result drives bus
alu_sub  output  1  ALU subtract select
load_a  output  1  accumulator loads bus at end of cycle
load_b  output  1  B operand register loads bus at end of cycle
out_load  output  1  output register loads bus at end of cycle
alu_cf  input  1  ALU carry out (combinational)
alu_zf  input  1  ALU zero (combinational)
cf  output  1  latched carry flag
zf  output  1  latched zero flag
done  output  1  one-cycle pulse in last execute cycle of each command
err  output  1  sticky illegal-opcode flag
op_count  output  CNT_W  completed commands (optional feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; all strobes, done, cf, zf, err and op_count = 0; latched op=NOP; imm_out=0.
- States: IDLE, EX1, EX2.
- IDLE:
  - cmd_ready=1; no strobes.
  - On cmd_valid&&cmd_ready, latch cmd_op and cmd_data, then go to EX1.
- cmd_ready=0 in EX1/EX2; cmd inputs are ignored there.
- Strobes and imm_out decode only from the state register and latched op. No combinational path from cmd_* to any output except cmd_ready (registered).
- EX1 by op:
  - LDA: in_oe, load_a; done; go to IDLE.
  - ADD/SUB: in_oe, load_b; go to EX2.
  - OUT: acc_oe, out_load; done; go to IDLE.
  - CLR: in_oe with imm_out forced 0, load_a; cf<=0, zf<=1; done; go to IDLE.
  - NOP: no strobes; done; go to IDLE.
  - Illegal: no strobes; err<=1; done; go to IDLE.
- EX2 (ADD/SUB only):
  - alu_oe, load_a, alu_sub=(op==SUB).
  - cf<=alu_cf, zf<=alu_zf at the end of the cycle; done; go to IDLE.
- Latency from accept edge: LDA/OUT/CLR/NOP have strobes 1 cycle after accept; ADD/SUB span 2 cycles. cmd_ready returns the cycle after done.
- Throughput with cmd_valid held high: one 1-cycle command per 2 clocks; ADD/SUB one per 3 clocks.
- Invariant: at most one of in_oe, acc_oe, alu_oe is high in any cycle; alu_sub=0 whenever alu_oe=0.
- cf/zf change only on ADD/SUB EX2 or CLR EX1; otherwise they hold.
- err is cleared only by reset.
- Reset mid-command: abort immediately, no further strobes; the accumulator keeps whatever it loaded before reset.

Optional Feature:
- Macro OPCOUNT_EN.
- Defined: op_count increments by 1 on every done pulse, including NOP and illegal; it wraps from 2^CNT_W-1 to 0 and resets to 0.
- Undefined: the op_count port still exists and is tied to 0; no counter flops.

Decomposition:
- Package acc_seq_pkg holds:
  - opcode constants OP_NOP..OP_CLR;
  - state enum IDLE/EX1/EX2;
  - a control-word struct {in_oe, acc_oe, alu_oe, alu_sub, load_a, load_b, out_load, done}.
- Sub-module acc_seq_decode: combinational (state, op) -> control word; it is the single point for checking the bus-exclusion invariant.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> all outputs 0 immediately, cmd_ready=1 after release.
- LDA 0x05, ADD 0x03, with the bench modelling the datapath:
  - ADD EX1 shows in_oe/load_b with imm_out=0x03;
  - EX2 shows alu_oe/load_a, acc=0x08, cf=0, zf=0;
  - done pulses once per command.
- LDA 0x08, SUB 0x08 (model drives alu_cf=1, alu_zf=1) -> alu_sub=1 in EX2 only, acc=0x00, cf=1, zf=1; a following OUT shows acc_oe+out_load, with cf/zf unchanged.
- cmd_valid held high with OUT,OUT,ADD:
  - accepts at cycles 0, 2, 4;
  - ADD done at cycle 6;
  - one-hot bus drivers checked every cycle.
- Reset asserted during ADD EX1 -> no EX2, load_a never pulses, state IDLE; CLR then gives zf=1, cf=0.
- Opcode 3'b111 -> no strobes, done pulse, err=1 sticky through later commands. With OPCOUNT_EN, 5 commands -> op_count=5.
